// File: rtl/common_pkg.sv
// Shared link defaults and helpers for the BFT switch datapath.
// Includes the occupancy-width helper used by the credit receive buffers.
package common_pkg;

    localparam int DEFAULT_A_W           = 3;
    localparam int DEFAULT_D_W           = 8;
    localparam int DEFAULT_VC_W          = 2;
    localparam int DEFAULT_VC_FIFO_DEPTH = 4;

    // Width of a per-VC occupancy count that can hold depth-1 entries.
    function automatic int CREDIT_RX_CNT_W(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/vc_fifo_credit.sv
// Single-VC receive FIFO holding DEPTH-1 flits with a registered credit pulse per pop.
// Pointers wrap by compare-and-reset, so DEPTH-1 need not be a power of two.
module vc_fifo_credit
    import common_pkg::*;
#(
    parameter  int FW      = 12,
    parameter  int DEPTH   = DEFAULT_VC_FIFO_DEPTH,
    localparam int CW      = CREDIT_RX_CNT_W(DEPTH),
    localparam int ENTRIES = DEPTH - 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [FW-1:0] din,
    input  logic          pop,
    output logic [FW-1:0] head,
    output logic          head_v,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          credit_gnt
);

    logic [FW-1:0] mem [ENTRIES];
    logic [CW-1:0] wr_ptr_reg, rd_ptr_reg, count_reg;
    logic          credit_reg;
    logic          pop_fire, push_fire;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CW'(ENTRIES));
    assign pop_fire  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_fire = push & (~full | pop_fire);

    function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
        return (p == CW'(ENTRIES - 1)) ? '0 : p + CW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            credit_reg <= 1'b0;
        end else begin
            credit_reg <= pop_fire;
            if (push_fire) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop_fire)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push_fire, pop_fire})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr_reg] <= din;
    end

    assign head       = empty ? '0 : mem[rd_ptr_reg];
    assign head_v     = ~empty;
    assign count      = count_reg;
    assign credit_gnt = credit_reg;

endmodule

// File: rtl/credit_vc_rx.sv
// Credit-based VC receive port: per-VC FIFOs, credit return and protocol checks.
// Define CREDIT_VC_RX_ERR_EN to enable error detection on err_o.
module credit_vc_rx
    import common_pkg::*;
#(
    parameter  int A_W           = DEFAULT_A_W,
    parameter  int D_W           = DEFAULT_D_W,
    parameter  int VC_W          = DEFAULT_VC_W,
    parameter  int VC_FIFO_DEPTH = DEFAULT_VC_FIFO_DEPTH,
    localparam int FW            = A_W + D_W + 1,
    localparam int CW            = CREDIT_RX_CNT_W(VC_FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FW-1:0]        link_i,
    input  logic [VC_W-1:0]      link_i_v,
    output logic [VC_W-1:0]      link_o_credit_gnt,
    output logic [VC_W*FW-1:0]   sw_o,
    output logic [VC_W-1:0]      sw_o_v,
    input  logic [VC_W-1:0]      sw_pop,
    output logic [VC_W*CW-1:0]   occ_o,
    output logic                 err_o
);

    logic [VC_W-1:0] push_vec;
    logic [VC_W-1:0] full_vec;
    logic [VC_W-1:0] empty_vec;

`ifdef CREDIT_VC_RX_ERR_EN
    logic multi_hot;
    logic err_reg;

    assign multi_hot = |(link_i_v & (link_i_v - VC_W'(1)));
    assign push_vec  = multi_hot ? '0 : link_i_v;

    // Overflow counts only when no same-cycle pop frees the slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_reg <= 1'b0;
        end else if (multi_hot
                     || |(link_i_v & full_vec & ~(sw_pop & ~empty_vec))
                     || |(sw_pop & empty_vec)) begin
            err_reg <= 1'b1;
        end
    end

    assign err_o = err_reg;
`else
    logic unused_status;

    // Lowest set VC wins when upstream violates one-hot.
    assign push_vec      = link_i_v & (~link_i_v + VC_W'(1));
    assign err_o         = 1'b0;
    assign unused_status = ^{full_vec, empty_vec};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < VC_W; gi++) begin : g_vc
            vc_fifo_credit #(
                .FW    (FW),
                .DEPTH (VC_FIFO_DEPTH)
            ) u_fifo (
                .clk        (clk),
                .rst        (rst),
                .push       (push_vec[gi]),
                .din        (link_i),
                .pop        (sw_pop[gi]),
                .head       (sw_o[gi*FW +: FW]),
                .head_v     (sw_o_v[gi]),
                .full       (full_vec[gi]),
                .empty      (empty_vec[gi]),
                .count      (occ_o[gi*CW +: CW]),
                .credit_gnt (link_o_credit_gnt[gi])
            );
        end
    endgenerate

endmodule
